// File: rtl/bip_run_controller.sv
// Run/step sequencer for the BIPI core, driven by UART debug commands.
// It owns the CPU enable and the CPU reset, and it counts the executed cycles.
// When execution stops, it sends a 5-byte report through the UART TX handshake:
// status, 16-bit cycle count, then 16-bit ACC.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | CPU out of reset and paused; waits for 'R' or 'S'
// CLEAR   | one cycle with the CPU in reset; clears the cycle counter
// RUN     | CPU free-running until HLT, watchdog or 'H'
// STEP    | CPU executes exactly one instruction
// LOAD    | puts the current report byte on o_tx_data and pulses o_tx_start
// TX_WAIT | waits for the UART to finish the current byte
module bip_run_controller #(
    parameter int CONTADOR_LENGTH = 11,
    parameter int OPCODE_LENGTH   = 5,
    parameter int ACC_LENGTH      = 16
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_rx_done,
    input  logic [7:0]                 i_rx_data,
    input  logic [OPCODE_LENGTH-1:0]   i_opcode,
    input  logic [ACC_LENGTH-1:0]      i_acc,
    input  logic                       i_tx_done,
    output logic                       o_cpu_enable,
    output logic                       o_cpu_reset,
    output logic                       o_tx_start,
    output logic [7:0]                 o_tx_data,
    output logic [CONTADOR_LENGTH-1:0] o_cuenta,
    output logic                       o_busy
);

    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_HALT = 8'h48;

    localparam logic [7:0] STATUS_HLT   = 8'h00;
    localparam logic [7:0] STATUS_WDOG  = 8'h01;
    localparam logic [7:0] STATUS_ABORT = 8'h02;
    localparam logic [7:0] STATUS_STEP  = 8'h03;

    localparam logic [CONTADOR_LENGTH-1:0] CNT_MAX = '1;
    localparam logic [2:0]                 LAST_IDX = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        STEP,
        LOAD,
        TX_WAIT
    } state_t;

    state_t                     state, state_next;
    logic [CONTADOR_LENGTH-1:0] cuenta_next, cuenta_inc;
    logic [7:0]                 status, status_next;
    logic [2:0]                 idx, idx_next;
    logic [15:0]                rpt_cnt, rpt_acc;
    logic [7:0]                 tx_byte;
    logic                       snapshot;

    // Compute the next state, the next counter and the next report-sequencing values.
    always_comb begin
        state_next  = state;
        cuenta_next = o_cuenta;
        status_next = status;
        idx_next    = idx;
        cuenta_inc  = o_cuenta + 1'b1;
        case (state)
            IDLE: begin
                if (i_rx_done) begin
                    if (i_rx_data == CMD_RUN) begin
                        state_next = CLEAR;
                    end else if (i_rx_data == CMD_STEP) begin
                        state_next = STEP;
                    end
                end
            end
            CLEAR: begin
                cuenta_next = '0;
                state_next  = RUN;
            end
            RUN: begin
                if (i_opcode == '0) begin
                    status_next = STATUS_HLT;
                    state_next  = LOAD;
                end else begin
                    cuenta_next = cuenta_inc;
                    if (cuenta_inc == CNT_MAX) begin
                        status_next = STATUS_WDOG;
                        state_next  = LOAD;
                    end else if (i_rx_done && (i_rx_data == CMD_HALT)) begin
                        status_next = STATUS_ABORT;
                        state_next  = LOAD;
                    end
                end
            end
            STEP: begin
                if ((i_opcode != '0) && (o_cuenta != CNT_MAX)) begin
                    cuenta_next = cuenta_inc;
                end
                status_next = STATUS_STEP;
                state_next  = LOAD;
            end
            LOAD: begin
                state_next = TX_WAIT;
            end
            TX_WAIT: begin
                if (i_tx_done) begin
                    if (idx == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx + 3'd1;
                        state_next = LOAD;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The report is frozen only when leaving RUN/STEP, never when coming back from TX_WAIT.
    assign snapshot = ((state == RUN) || (state == STEP)) && (state_next == LOAD);

    // Select the report byte for the current index.
    always_comb begin
        tx_byte = 8'h00;
        case (idx)
            3'd0:    tx_byte = status;
            3'd1:    tx_byte = rpt_cnt[15:8];
            3'd2:    tx_byte = rpt_cnt[7:0];
            3'd3:    tx_byte = rpt_acc[15:8];
            default: tx_byte = rpt_acc[7:0];
        endcase
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered outputs and datapath. CPU controls follow the state being entered.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_cpu_enable <= 1'b0;
            o_cpu_reset  <= 1'b0;
            o_tx_start   <= 1'b0;
            o_tx_data    <= '0;
            o_cuenta     <= '0;
            o_busy       <= 1'b0;
            status       <= '0;
            idx          <= '0;
            rpt_cnt      <= '0;
            rpt_acc      <= '0;
        end else begin
            o_cpu_enable <= (state_next == RUN) || (state_next == STEP);
            o_cpu_reset  <= (state_next != CLEAR);
            o_tx_start   <= (state == LOAD);
            o_busy       <= (state_next != IDLE);
            o_cuenta     <= cuenta_next;
            status       <= status_next;
            idx          <= idx_next;
            if (state == LOAD) begin
                o_tx_data <= tx_byte;
            end
            if (snapshot) begin
                rpt_cnt <= 16'(cuenta_next);
                rpt_acc <= 16'(i_acc);
            end
        end
    end

endmodule

// File: tb/tb_bip_run_controller.sv
// Directed bench for bip_run_controller.
// The expected report bytes go into a queue when each command is issued.
// A monitor pops one byte for every o_tx_start and compares it.
// A small UART model answers each start with a delayed tx_done pulse.
module tb_bip_run_controller;

    logic        i_clock;
    logic        i_reset;
    logic        i_rx_done;
    logic [7:0]  i_rx_data;
    logic [4:0]  i_opcode;
    logic [15:0] i_acc;
    logic        i_tx_done;
    logic        o_cpu_enable;
    logic        o_cpu_reset;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic [10:0] o_cuenta;
    logic        o_busy;

    int checks = 0;
    int errors = 0;
    int tx_seen = 0;
    logic [7:0] exp_q[$];

    bip_run_controller #(
        .CONTADOR_LENGTH(11),
        .OPCODE_LENGTH  (5),
        .ACC_LENGTH     (16)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_rx_done   (i_rx_done),
        .i_rx_data   (i_rx_data),
        .i_opcode    (i_opcode),
        .i_acc       (i_acc),
        .i_tx_done   (i_tx_done),
        .o_cpu_enable(o_cpu_enable),
        .o_cpu_reset (o_cpu_reset),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .o_cuenta    (o_cuenta),
        .o_busy      (o_busy)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
        exp_q.push_back(b4);
    endtask

    // Called at a negedge; holds the byte valid across exactly one rising edge.
    task automatic send_rx(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clock);
        i_rx_done = 1'b0;
    endtask

    task automatic wait_enable();
        int n = 0;
        while (!o_cpu_enable && n < 10) begin
            @(negedge i_clock);
            n++;
        end
        check("enable_timeout", o_cpu_enable, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            @(negedge i_clock);
            n++;
        end
        check("idle_timeout", o_busy, 1'b0);
        repeat (2) @(negedge i_clock);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Scoreboard monitor: one expected byte per start pulse.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge i_clock);
            if (o_tx_start) begin
                tx_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_tx_start", o_tx_start, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", o_tx_data, e);
                end
            end
        end
    end

    // UART transmitter model.
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge i_clock);
            if (o_tx_start) begin
                repeat (3) @(negedge i_clock);
                i_tx_done = 1'b1;
                @(negedge i_clock);
                i_tx_done = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int n;
        i_reset   = 1'b0;
        i_rx_done = 1'b0;
        i_rx_data = 8'h00;
        i_opcode  = 5'd0;
        i_acc     = 16'h0000;

        // 1: reset, then idle
        repeat (3) @(negedge i_clock);
        check("rst_cpu_reset", o_cpu_reset, 1'b0);
        check("rst_tx_data", o_tx_data, 8'h00);
        i_reset = 1'b1;
        repeat (20) @(negedge i_clock);
        check("idle_enable", o_cpu_enable, 1'b0);
        check("idle_cuenta", o_cuenta, 11'd0);
        check("idle_busy", o_busy, 1'b0);
        check("idle_cpu_reset", o_cpu_reset, 1'b1);
        check("idle_tx_seen", tx_seen, 0);
        send_rx(8'h41);
        @(negedge i_clock);
        check("ignored_byte_busy", o_busy, 1'b0);

        // 2: run 7 cycles then HLT; ACC changes after the snapshot
        i_opcode = 5'd3;
        i_acc    = 16'h1234;
        push5(8'h00, 8'h00, 8'h07, 8'h12, 8'h34);
        send_rx(8'h52);
        check("clear_enable", o_cpu_enable, 1'b0);
        check("clear_cpu_reset", o_cpu_reset, 1'b0);
        check("clear_busy", o_busy, 1'b1);
        @(negedge i_clock);
        check("run_enable_latency", o_cpu_enable, 1'b1);
        check("run_cpu_reset", o_cpu_reset, 1'b1);
        repeat (7) @(negedge i_clock);
        i_opcode = 5'd0;
        @(negedge i_clock);
        check("halt_enable_off", o_cpu_enable, 1'b0);
        check("halt_tx_start_early", o_tx_start, 1'b0);
        check("halt_cuenta", o_cuenta, 11'd7);
        i_acc = 16'hBEEF;
        @(negedge i_clock);
        check("halt_tx_start_latency", o_tx_start, 1'b1);
        wait_idle(200);
        check("t2_cuenta", o_cuenta, 11'd7);

        // 3: watchdog saturation
        i_opcode = 5'd1;
        i_acc    = 16'hCAFE;
        push5(8'h01, 8'h07, 8'hFF, 8'hCA, 8'hFE);
        send_rx(8'h52);
        wait_idle(3000);
        check("wdog_cuenta", o_cuenta, 11'h7FF);

        // 4: user abort after 3 cycles, then a single step
        i_opcode = 5'd2;
        i_acc    = 16'h0102;
        push5(8'h02, 8'h00, 8'h03, 8'h01, 8'h02);
        send_rx(8'h52);
        wait_enable();
        repeat (2) @(negedge i_clock);
        send_rx(8'h48);
        wait_idle(200);
        check("abort_cuenta", o_cuenta, 11'd3);
        i_acc = 16'h0304;
        push5(8'h03, 8'h00, 8'h04, 8'h03, 8'h04);
        send_rx(8'h53);
        check("step_enable", o_cpu_enable, 1'b1);
        wait_idle(200);
        check("step_cuenta", o_cuenta, 11'd4);

        // 5: HLT and 'H' on the same edge, then step over HLT
        i_opcode = 5'd1;
        i_acc    = 16'h5A5A;
        push5(8'h00, 8'h00, 8'h01, 8'h5A, 8'h5A);
        send_rx(8'h52);
        wait_enable();
        @(negedge i_clock);
        i_opcode = 5'd0;
        send_rx(8'h48);
        wait_idle(200);
        check("hlt_wins_cuenta", o_cuenta, 11'd1);
        push5(8'h03, 8'h00, 8'h01, 8'h5A, 8'h5A);
        send_rx(8'h53);
        wait_idle(200);
        check("step_hlt_cuenta", o_cuenta, 11'd1);

        // 6: reset during TX_WAIT of byte 2
        i_opcode = 5'd1;
        i_acc    = 16'h7777;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h02);
        base = tx_seen;
        send_rx(8'h52);
        wait_enable();
        repeat (2) @(negedge i_clock);
        i_opcode = 5'd0;
        n = 0;
        while (tx_seen < base + 3 && n < 100) begin
            @(negedge i_clock);
            n++;
        end
        check("t6_reach_byte2", tx_seen, base + 3);
        i_reset = 1'b0;
        @(negedge i_clock);
        check("t6_cpu_reset", o_cpu_reset, 1'b0);
        check("t6_busy", o_busy, 1'b0);
        check("t6_cuenta", o_cuenta, 11'd0);
        check("t6_enable", o_cpu_enable, 1'b0);
        @(negedge i_clock);
        i_reset = 1'b1;
        repeat (20) @(negedge i_clock);
        check("t6_no_more_tx", tx_seen, base + 3);
        check("t6_busy_after", o_busy, 1'b0);
        check("t6_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
